// File: rtl/riscv_pkg.sv
// riscv_pkg: shared encodings for the RV32I execute stage.
package riscv_pkg;
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;
endpackage

// File: rtl/execute_cycle_alu.sv
// alu: combinational RV32I ALU; undefined op codes yield zero.
module alu
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] SrcB,
    input  logic [2:0]      ALUControl,
    output logic [XLEN-1:0] ALUResult,
    output logic            Zero
);
    logic w_slt;

    always_comb begin
        w_slt     = $signed(SrcA) < $signed(SrcB);
        ALUResult = ALUControl == ALU_ADD ? SrcA + SrcB :
                    ALUControl == ALU_SUB ? SrcA - SrcB :
                    ALUControl == ALU_AND ? SrcA & SrcB :
                    ALUControl == ALU_OR  ? SrcA | SrcB :
                    ALUControl == ALU_XOR ? SrcA ^ SrcB :
                    ALUControl == ALU_SLT ? {{(XLEN-1){1'b0}}, w_slt} : '0;
        Zero      = ALUResult == '0;
    end
endmodule

// File: rtl/execute_cycle.sv
// execute_cycle: RV32I EX stage - operand forwarding, ALU, branch/jump
// resolution and the EX/MEM pipeline register.
module execute_cycle
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] RD1_E,
    input  logic [XLEN-1:0] RD2_E,
    input  logic [XLEN-1:0] ImmExtE,
    input  logic [XLEN-1:0] PCE,
    input  logic [XLEN-1:0] PCPlus4E,
    input  logic [31:0]     InstrE,
    input  logic [4:0]      RdE,
    input  logic            RegWriteE,
    input  logic            MemWriteE,
    input  logic            JumpE,
    input  logic            jalrE,
    input  logic            BranchE,
    input  logic            ALUSrcE,
    input  logic [2:0]      ALUControlE,
    input  logic [1:0]      ResultSrcE,
    input  logic [1:0]      ForwardAE,
    input  logic [1:0]      ForwardBE,
    input  logic [XLEN-1:0] ResultW,
    output logic            PCSrcE,
    output logic [XLEN-1:0] PCTargetE,
    output logic [XLEN-1:0] ALUResultM,
    output logic [XLEN-1:0] WriteDataM,
    output logic [XLEN-1:0] PCPlus4M,
    output logic [4:0]      RdM,
    output logic            RegWriteM,
    output logic            MemWriteM,
    output logic [1:0]      ResultSrcM
);
    logic [XLEN-1:0] r_alu_m, r_wd_m, r_pc4_m;
    logic [4:0]      r_rd_m;
    logic            r_rw_m, r_mw_m;
    logic [1:0]      r_rs_m;

    logic [XLEN-1:0] w_src_a, w_fwd_b, w_src_b, w_alu_res;
    logic [2:0]      w_f3;
    logic            w_zero, w_taken;
    logic            w_unused;

    // The MEM-stage forward taps the registered result, so there is no loop through the ALU.
    always_comb begin
        w_src_a = ForwardAE == FWD_WB ? ResultW : ForwardAE == FWD_MEM ? r_alu_m : RD1_E;
        w_fwd_b = ForwardBE == FWD_WB ? ResultW : ForwardBE == FWD_MEM ? r_alu_m : RD2_E;
        w_src_b = ALUSrcE ? ImmExtE : w_fwd_b;
        w_f3    = InstrE[14:12];
        w_taken = w_f3 == F3_BEQ  ? w_src_a == w_fwd_b :
                  w_f3 == F3_BNE  ? w_src_a != w_fwd_b :
                  w_f3 == F3_BLT  ? $signed(w_src_a) <  $signed(w_fwd_b) :
                  w_f3 == F3_BGE  ? $signed(w_src_a) >= $signed(w_fwd_b) :
                  w_f3 == F3_BLTU ? w_src_a <  w_fwd_b :
                  w_f3 == F3_BGEU ? w_src_a >= w_fwd_b : 1'b0;
        PCSrcE    = JumpE | (BranchE & w_taken);
        PCTargetE = jalrE ? ((w_src_a + ImmExtE) & ~{{(XLEN-1){1'b0}}, 1'b1}) : PCE + ImmExtE;
    end

    alu #(.XLEN(XLEN)) u_alu (
        .SrcA       (w_src_a),
        .SrcB       (w_src_b),
        .ALUControl (ALUControlE),
        .ALUResult  (w_alu_res),
        .Zero       (w_zero)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_alu_m <= '0;
            r_wd_m  <= '0;
            r_pc4_m <= '0;
            r_rd_m  <= '0;
            r_rw_m  <= 1'b0;
            r_mw_m  <= 1'b0;
            r_rs_m  <= '0;
        end else begin
            r_alu_m <= w_alu_res;
            r_wd_m  <= w_fwd_b;
            r_pc4_m <= PCPlus4E;
            r_rd_m  <= RdE;
            r_rw_m  <= RegWriteE;
            r_mw_m  <= MemWriteE;
            r_rs_m  <= ResultSrcE;
        end
    end

    assign ALUResultM = r_alu_m;
    assign WriteDataM = r_wd_m;
    assign PCPlus4M   = r_pc4_m;
    assign RdM        = r_rd_m;
    assign RegWriteM  = r_rw_m;
    assign MemWriteM  = r_mw_m;
    assign ResultSrcM = r_rs_m;
    assign w_unused   = &{1'b0, InstrE[31:15], InstrE[11:0], w_zero};
endmodule

// File: tb/tb_execute_cycle.sv
// tb_execute_cycle: directed vectors with a queue scoreboard on the EX/MEM register
// and immediate checks on the combinational redirect outputs.
module tb_execute_cycle;
    import riscv_pkg::*;

    logic        clk = 1'b0, rst = 1'b0;
    logic [31:0] RD1_E, RD2_E, ImmExtE, PCE, PCPlus4E, InstrE, ResultW;
    logic [4:0]  RdE;
    logic        RegWriteE, MemWriteE, JumpE, jalrE, BranchE, ALUSrcE;
    logic [2:0]  ALUControlE;
    logic [1:0]  ResultSrcE, ForwardAE, ForwardBE;
    logic        PCSrcE;
    logic [31:0] PCTargetE, ALUResultM, WriteDataM, PCPlus4M;
    logic [4:0]  RdM;
    logic        RegWriteM, MemWriteM;
    logic [1:0]  ResultSrcM;

    typedef struct packed {
        logic [31:0] alu, wd, pc4;
        logic [4:0]  rd;
        logic        rw, mw;
        logic [1:0]  rs;
    } exp_t;

    exp_t q[$];
    exp_t got, m_e;
    int   checks = 0, errors = 0;

    execute_cycle #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .RD1_E(RD1_E), .RD2_E(RD2_E), .ImmExtE(ImmExtE),
        .PCE(PCE), .PCPlus4E(PCPlus4E), .InstrE(InstrE), .RdE(RdE),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE), .jalrE(jalrE),
        .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
        .ResultSrcE(ResultSrcE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .ResultW(ResultW), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M),
        .RdM(RdM), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM)
    );

    always #5 clk = ~clk;

    assign got = {ALUResultM, WriteDataM, PCPlus4M, RdM, RegWriteM, MemWriteM, ResultSrcM};

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every captured EX/MEM value is compared with the oldest expectation.
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            m_e = q.pop_front();
            checks++;
            if (got !== m_e) begin
                errors++;
                $display("FAIL exmem: got alu=%h wd=%h pc4=%h rd=%0d rw=%b mw=%b rs=%0d expected alu=%h wd=%h pc4=%h rd=%0d rw=%b mw=%b rs=%0d",
                         got.alu, got.wd, got.pc4, got.rd, got.rw, got.mw, got.rs,
                         m_e.alu, m_e.wd, m_e.pc4, m_e.rd, m_e.rw, m_e.mw, m_e.rs);
            end
        end
    end

    task automatic idle();
        {RD1_E, RD2_E, ImmExtE, PCE, PCPlus4E, InstrE, ResultW} = '0;
        RdE = '0;
        {RegWriteE, MemWriteE, JumpE, jalrE, BranchE, ALUSrcE} = '0;
        ALUControlE = ALU_ADD;
        {ResultSrcE, ForwardAE, ForwardBE} = '0;
    endtask

    task automatic step(input logic [31:0] ea, input logic [31:0] ew);
        q.push_back({ea, ew, PCPlus4E, RdE, RegWriteE, MemWriteE, ResultSrcE});
        @(negedge clk);
    endtask

    task automatic chk_pc(input string name, input logic es, input logic [31:0] et);
        #1;
        check({name, "_pcsrc"}, {127'b0, PCSrcE}, {127'b0, es});
        check({name, "_target"}, {96'b0, PCTargetE}, {96'b0, et});
    endtask

    logic [2:0]  ops[8]  = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, 3'b110, 3'b111};
    logic [31:0] ores[8] = '{32'h0, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1, 32'h0, 32'h0};
    logic [2:0]  f3s[8]  = '{3'b100, 3'b110, 3'b101, 3'b111, 3'b000, 3'b001, 3'b010, 3'b011};
    logic        tks[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

    initial begin
        idle();
        {RD1_E, RD2_E, ImmExtE, PCE, PCPlus4E, ResultW} = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        RdE = 5'($urandom);
        {RegWriteE, MemWriteE, ALUControlE, ResultSrcE, ForwardAE, ForwardBE} = 11'($urandom);
        repeat (2) @(negedge clk);
        check("reset_hold", {52'b0, got}, 128'b0);

        // release reset; first edge captures
        idle();
        RD1_E = 32'd3; RD2_E = 32'd4; RdE = 5'd5; RegWriteE = 1'b1; PCPlus4E = 32'h104;
        rst = 1'b1;
        step(32'd7, 32'd4);

        idle();
        RD1_E = 32'hFFFFFFFF; RD2_E = 32'h1; RdE = 5'd6; RegWriteE = 1'b1; MemWriteE = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ALUControlE = ops[i];
            step(ores[i], 32'h1);
        end
        ALUControlE = ALU_ADD; ALUSrcE = 1'b1; ImmExtE = 32'h10;
        step(32'h0F, 32'h1);

        // forwarding
        idle();
        RD1_E = 32'h20; RD2_E = 32'h20; ResultSrcE = RES_MEM;
        step(32'h40, 32'h20);
        ForwardAE = FWD_MEM; ForwardBE = FWD_WB; ResultW = 32'h2; RD1_E = '0; RD2_E = '0;
        step(32'h42, 32'h2);
        ForwardAE = 2'b11; ForwardBE = 2'b11; RD1_E = 32'd5; RD2_E = 32'd6;
        step(32'h0B, 32'h6);
        ForwardAE = FWD_RF; ForwardBE = FWD_MEM; RD1_E = 32'h50; ALUControlE = ALU_SUB;
        step(32'h45, 32'h0B);

        // branches compare forwarded operands even with an immediate on SrcB
        idle();
        BranchE = 1'b1; RD1_E = 32'hFFFFFFFF; RD2_E = 32'h1; PCE = 32'h1000; ImmExtE = 32'h20;
        ALUSrcE = 1'b1;
        for (int i = 0; i < 8; i++) begin
            InstrE = {17'b0, f3s[i], 12'b0};
            chk_pc($sformatf("br_f3_%0d", f3s[i]), tks[i], 32'h1020);
            step(32'h1F, 32'h1);
        end
        RD2_E = 32'hFFFFFFFF; InstrE = {17'b0, F3_BEQ, 12'b0};
        chk_pc("beq_eq", 1'b1, 32'h1020);
        step(32'h1F, 32'hFFFFFFFF);
        BranchE = 1'b0;
        chk_pc("nobranch", 1'b0, 32'h1020);
        step(32'h1F, 32'hFFFFFFFF);

        // jalr then jal
        idle();
        JumpE = 1'b1; jalrE = 1'b1; RD1_E = 32'h1001; ImmExtE = 32'h4; ALUSrcE = 1'b1;
        PCE = 32'h2000; PCPlus4E = 32'h2004; RegWriteE = 1'b1; ResultSrcE = RES_PC4; RdE = 5'd1;
        chk_pc("jalr", 1'b1, 32'h1004);
        step(32'h1005, 32'h0);
        jalrE = 1'b0;
        chk_pc("jal", 1'b1, 32'h2004);
        step(32'h1005, 32'h0);

        // mid-run asynchronous reset, no clock edge in between
        rst = 1'b0;
        #1;
        check("async_reset", {52'b0, got}, 128'b0);
        @(negedge clk);
        idle();
        rst = 1'b1; RD1_E = 32'd9; RD2_E = 32'd1; ALUControlE = ALU_SUB; RdE = 5'd31; RegWriteE = 1'b1;
        step(32'd8, 32'd1);

        repeat (3) @(negedge clk);
        check("queue_drained", 128'(q.size()), 128'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/execute_cycle.md
Name: execute_cycle

Overview:
- EX stage of the 5-stage RV32I pipeline; sits directly downstream of the decode stage and consumes its ID/EX register outputs.
- Selects forwarded operands, executes the ALU op, resolves branches and jumps (PCSrcE/PCTargetE back to fetch), and holds the EX/MEM pipeline register feeding the memory stage.

Parameters:
XLEN, 32, datapath width (only 32 supported)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
RD1_E  in  XLEN  rs1 read data from ID/EX
RD2_E  in  XLEN  rs2 read data from ID/EX
ImmExtE  in  XLEN  sign-extended immediate
PCE  in  XLEN  instruction PC
PCPlus4E  in  XLEN  PC+4
InstrE  in  32  instruction word; funct3 = InstrE[14:12]
RdE  in  5  destination register
RegWriteE, MemWriteE, JumpE, jalrE, BranchE, ALUSrcE  in  1 each  control from decode
ALUControlE  in  3  ALU op
ResultSrcE  in  2  writeback select, passed through
ForwardAE, ForwardBE  in  2 each  forward selects from the hazard unit
ResultW  in  XLEN  writeback-stage result for forwarding
PCSrcE  out  1  redirect fetch (combinational)
PCTargetE  out  XLEN  redirect target (combinational)
ALUResultM, WriteDataM, PCPlus4M  out  XLEN each  EX/MEM register
RdM  out  5  EX/MEM register
RegWriteM, MemWriteM  out  1 each  EX/MEM register
ResultSrcM  out  2  EX/MEM register

Behaviour:
- Forward mux A/B: 00 → RD1_E/RD2_E; 01 → ResultW; 10 → ALUResultM (registered output); 11 → same as 00.
- SrcAE = fwdA. WriteDataE = fwdB. SrcBE = ALUSrcE ? ImmExtE : fwdB.
- ALUControlE: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt (signed, result 1 or 0), 110/111 → 0. Arithmetic wraps modulo 2^32.
- Branch compare uses fwdA and fwdB independent of ALUSrcE, by funct3:
  - 000 beq, 001 bne, 100 blt (signed), 101 bge (signed), 110 bltu, 111 bgeu.
  - 010/011 → not taken.
- PCSrcE = JumpE | (BranchE & taken).
- PCTargetE = jalrE ? ((SrcAE + ImmExtE) & ~1) : (PCE + ImmExtE). Both are combinational, no latency.
- EX/MEM register: on every rising clk it captures ALUResultE, WriteDataE, PCPlus4E, RdE, RegWriteE, MemWriteE, ResultSrcE. Latency is 1 cycle. No stall or flush inputs; bubbles arrive from upstream as zeroed controls.
- Reset (rst=0): all M outputs are immediately 0, asynchronously, including mid-operation. The first capture happens on the first rising clk after rst deasserts.
- ALUResultM is used for forwarding at the same time the register updates: the mux sees the pre-edge value in the same cycle. There is no combinational loop.
- Simultaneous ForwardAE=10 and ForwardBE=01 is legal; each mux is independent.
- A jump with RegWriteE=1 still registers PCPlus4E. ResultSrc selection happens in writeback.

Decomposition:
- Package riscv_pkg holds:
  - ALU op localparams (ALU_ADD…ALU_SLT)
  - forward-select codes (FWD_RF, FWD_WB, FWD_MEM)
  - ResultSrc codes (RES_ALU, RES_MEM, RES_PC4)
  - branch funct3 codes
- Sub-module alu (SrcA, SrcB, ALUControl → ALUResult, Zero). It is combinational and instantiated once; branch compare stays local to execute_cycle.

Test Plan:
- Reset: hold rst=0 with random inputs, then toggle clk → all M outputs 0; release rst, first edge captures RdE=5, ALUResultM=RD1_E+RD2_E.
- ALU ops: RD1_E=0xFFFFFFFF, RD2_E=1 → add → 0 (wrap), sub → 0xFFFFFFFE, slt → 1, xor → 0xFFFFFFFE; ALUSrcE=1 with ImmExtE=0x10 → add gives 0x0F.
- Forwarding: ForwardAE=10 with ALUResultM=0x40, ForwardBE=01 with ResultW=0x2 → next ALUResultM=0x42 (add) and WriteDataM=0x2.
- Branches: BranchE=1, funct3=100, fwdA=-1, fwdB=1 → PCSrcE=1, PCTargetE=PCE+Imm; funct3=110 with the same values → PCSrcE=0.
- jalr: jalrE=1, JumpE=1, SrcA=0x1001, Imm=0x4 → PCTargetE=0x1004, PCSrcE=1, PCPlus4M=PCE+4 next cycle.
- Mid-run reset: assert rst between edges → M outputs go to 0 without a clk edge.
